// File: rtl/minmax_pkg.sv
// Shared types and constants for the min/max tracking stage.
package minmax_pkg;

    localparam int unsigned DATAWIDTH_DEF = 8;
    localparam int unsigned CNTWIDTH_DEF  = 8;

    // Saturation value of the sample counter at the default width.
    localparam int unsigned CNT_SAT_DEF = (1 << CNTWIDTH_DEF) - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/minmax_cmp_unit.sv
// Combinational unsigned compare of a sample against the running max and min.
module minmax_cmp_unit
    import minmax_pkg::*;
#(
    parameter int unsigned DATAWIDTH = DATAWIDTH_DEF
) (
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic [DATAWIDTH-1:0] cur_max,
    input  logic [DATAWIDTH-1:0] cur_min,
    output logic                 upd_max,
    output logic                 upd_min
);

    // Strict compares: a sample equal to the current extreme leaves it untouched.
    always_comb begin
        upd_max = (in_data > cur_max);
        upd_min = (in_data < cur_min);
    end

endmodule

// File: rtl/minmax_tracker.sv
// Framed running max/min/count tracker with valid/ready handshake on both sides.
// Optional overflow flag enabled by defining MINMAX_TRACKER_OVF_EN.
module minmax_tracker
    import minmax_pkg::*;
#(
    parameter int unsigned DATAWIDTH = DATAWIDTH_DEF,
    parameter int unsigned CNTWIDTH  = CNTWIDTH_DEF
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 in_valid,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [DATAWIDTH-1:0] out_max,
    output logic [DATAWIDTH-1:0] out_min,
    output logic [CNTWIDTH-1:0]  out_count,
    input  logic                 out_ready
`ifdef MINMAX_TRACKER_OVF_EN
    ,
    output logic                 out_ovf
`endif
);

    localparam logic [CNTWIDTH-1:0] CNT_SAT = {CNTWIDTH{1'b1}};

    state_e               state_q, state_d;
    logic [DATAWIDTH-1:0] max_q, max_d;
    logic [DATAWIDTH-1:0] min_q, min_d;
    logic [CNTWIDTH-1:0]  cnt_q, cnt_d;
    logic                 ready_int;
    logic                 accept;
    logic                 upd_max, upd_min;

    minmax_cmp_unit #(
        .DATAWIDTH (DATAWIDTH)
    ) u_cmp (
        .in_data (in_data),
        .cur_max (max_q),
        .cur_min (min_q),
        .upd_max (upd_max),
        .upd_min (upd_min)
    );

    assign ready_int = (state_q == IDLE) || (state_q == ACCUM);
    assign accept    = in_valid && ready_int;
    // The state register already sits in IDLE during reset, so mask ready explicitly.
    assign in_ready  = ready_int && !Rst;

    always_comb begin
        state_d   = state_q;
        max_d     = max_q;
        min_d     = min_q;
        cnt_d     = cnt_q;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    max_d   = in_data;
                    min_d   = in_data;
                    cnt_d   = CNTWIDTH'(1);
                    state_d = in_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (upd_max) max_d = in_data;
                    if (upd_min) min_d = in_data;
                    if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
                    if (in_last) state_d = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            max_q   <= '0;
            min_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            max_q   <= max_d;
            min_q   <= min_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_max   = max_q;
    assign out_min   = min_q;
    assign out_count = cnt_q;

`ifdef MINMAX_TRACKER_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (accept && state_q == IDLE) begin
            ovf_d = 1'b0;
        end else if (accept && state_q == ACCUM && cnt_q == CNT_SAT) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign out_ovf = ovf_q;
`else
    // Without the flag, counter saturation is silent.
`endif

endmodule
